// File: rtl/hex_rate_counter_pkg.sv
// -----------------------------------------------------------------------------
// hex_rate_counter_pkg
// Shared definitions for the hex rate counter:
//   speed_e       - rate select encodings (full rate, 1x, 2x, 4x CLK_HZ periods)
//   HEX_W         - width of the displayed nibble
//   reload_value  - maps a rate select to the divider reload value N-1
// -----------------------------------------------------------------------------
package hex_rate_counter_pkg;

  typedef enum logic [1:0] {
    SPEED_FULL = 2'b00,
    SPEED_1S   = 2'b01,
    SPEED_2S   = 2'b10,
    SPEED_4S   = 2'b11
  } speed_e;

  localparam int unsigned HEX_W = 4;

  // Divider reload value (period minus one) for a given rate select.
  // Callers truncate to their divider width, which must hold 4*clk_hz-1.
  function automatic logic [31:0] reload_value(input logic [1:0] speed,
                                                input int unsigned clk_hz);
    logic [31:0] r;
    r = '0;
    case (speed_e'(speed))
      SPEED_FULL: r = 32'd0;
      SPEED_1S:   r = clk_hz - 32'd1;
      SPEED_2S:   r = (32'd2 * clk_hz) - 32'd1;
      SPEED_4S:   r = (32'd4 * clk_hz) - 32'd1;
      default:    r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hex_rate_counter_if.sv
// -----------------------------------------------------------------------------
// hex_rate_counter_if
// Control and display bundle of the hex rate counter.
//   enable      - counting enable (low freezes divider and counter)
//   speed       - rate select (see speed_e)
//   up          - 1 = increment, 0 = decrement
//   load        - synchronous parallel load
//   load_value  - value taken on load
//   tick        - registered one-cycle pulse on every counter update
//   hex_value   - current count, feeds the seven-segment decoder
// master drives the controls, slave (the counter) drives tick/hex_value.
// -----------------------------------------------------------------------------
interface hex_rate_counter_if;
  import hex_rate_counter_pkg::*;

  logic             enable;
  logic [1:0]       speed;
  logic             up;
  logic             load;
  logic [HEX_W-1:0] load_value;
  logic             tick;
  logic [HEX_W-1:0] hex_value;

  modport master (
    output enable, speed, up, load, load_value,
    input  tick, hex_value
  );

  modport slave (
    input  enable, speed, up, load, load_value,
    output tick, hex_value
  );
endinterface

// File: rtl/hex_rate_counter_rate_divider.sv
// -----------------------------------------------------------------------------
// hex_rate_counter_rate_divider
// Programmable down-counting divider producing one advance per period.
//   clk, resetn   - clock, asynchronous active-low reset
//   enable        - low freezes the divider
//   speed         - requested rate; a change restarts a full period
//   force_reload  - reload from 'speed' regardless of enable (parallel load)
//   advance       - combinational: the counter must step on this edge
//   tick          - registered copy of advance, aligned with the count change
// -----------------------------------------------------------------------------
module hex_rate_counter_rate_divider
  import hex_rate_counter_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned DIV_W  = 28
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       force_reload,
  output logic       advance,
  output logic       tick
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       speed_q, speed_d;
  logic             tick_q, tick_d;

  function automatic logic [DIV_W-1:0] reload_of(input logic [1:0] s);
    return DIV_W'(reload_value(s, CLK_HZ));
  endfunction

  always_comb begin
    div_d   = div_q;
    speed_d = speed_q;
    tick_d  = 1'b0;
    if (force_reload || (speed != speed_q)) begin
      // Any reload starts a fresh full period at the requested rate.
      div_d   = reload_of(speed);
      speed_d = speed;
    end else if (enable) begin
      if (div_q == '0) begin
        div_d  = reload_of(speed_q);
        tick_d = 1'b1;
      end else begin
        div_d = div_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q   <= '0;
      speed_q <= SPEED_FULL;
      tick_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      speed_q <= speed_d;
      tick_q  <= tick_d;
    end
  end

  assign advance = tick_d;
  assign tick    = tick_q;

endmodule

// File: rtl/hex_rate_counter.sv
// -----------------------------------------------------------------------------
// hex_rate_counter
// 4-bit up/down hex counter stepped by a programmable rate divider; its
// hex_value drives a seven-segment decoder directly.
//   clk, resetn - clock, asynchronous active-low reset
//   bus         - slave side of hex_rate_counter_if (controls in,
//                 tick/hex_value out, both registered)
// -----------------------------------------------------------------------------
module hex_rate_counter
  import hex_rate_counter_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned DIV_W  = 28
) (
  input  logic               clk,
  input  logic               resetn,
  hex_rate_counter_if.slave  bus
);

  logic             advance;
  logic             tick;
  logic [HEX_W-1:0] hex_q, hex_d;

  hex_rate_counter_rate_divider #(
    .CLK_HZ (CLK_HZ),
    .DIV_W  (DIV_W)
  ) u_rate_divider (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (bus.enable),
    .speed        (bus.speed),
    .force_reload (bus.load),
    .advance      (advance),
    .tick         (tick)
  );

  // Load wins over stepping; the divider never advances on a load edge,
  // so the two cannot collide. Direction is sampled only on the step edge.
  always_comb begin
    hex_d = hex_q;
    if (bus.load) begin
      hex_d = bus.load_value;
    end else if (advance) begin
      hex_d = bus.up ? (hex_q + 4'd1) : (hex_q - 4'd1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hex_q <= '0;
    end else begin
      hex_q <= hex_d;
    end
  end

  assign bus.tick      = tick;
  assign bus.hex_value = hex_q;

endmodule

// File: tb/tb_hex_rate_counter.sv
// -----------------------------------------------------------------------------
// tb_hex_rate_counter
// Scoreboard bench: each driven cycle pushes the expected {tick, hex_value}
// from a behavioural model (elapsed enabled cycles vs. period length); a
// monitor pops and compares after every edge. Directed checks cover reset,
// wrap-around, load, freeze and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_hex_rate_counter;

  localparam int unsigned CLK_HZ = 4;
  localparam int unsigned DIV_W  = 28;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  hex_rate_counter_if bus ();

  hex_rate_counter #(
    .CLK_HZ (CLK_HZ),
    .DIV_W  (DIV_W)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct packed {
    logic       tick;
    logic [3:0] hex;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Behavioural model state
  logic [3:0] hex_m;
  logic [1:0] speed_m;
  int         elapsed_m;
  logic       tick_m;

  function automatic int period_of(input logic [1:0] s);
    case (s)
      2'd0:    return 1;
      2'd1:    return CLK_HZ;
      2'd2:    return 2 * CLK_HZ;
      default: return 4 * CLK_HZ;
    endcase
  endfunction

  task automatic model_reset();
    hex_m     = 4'h0;
    speed_m   = 2'b00;
    elapsed_m = 0;
    tick_m    = 1'b0;
  endtask

  task automatic model_edge(input logic en, input logic [1:0] spd, input logic upv,
                            input logic ld, input logic [3:0] lv);
    tick_m = 1'b0;
    if (ld) begin
      hex_m     = lv;
      speed_m   = spd;
      elapsed_m = 0;
    end else if (spd != speed_m) begin
      speed_m   = spd;
      elapsed_m = 0;
    end else if (en) begin
      elapsed_m++;
      if (elapsed_m == period_of(speed_m)) begin
        elapsed_m = 0;
        tick_m    = 1'b1;
        hex_m     = upv ? hex_m + 4'd1 : hex_m - 4'd1;
      end
    end
  endtask

  // Apply one cycle of stimulus at the falling edge and queue its expectation.
  task automatic drive(input logic en, input logic [1:0] spd, input logic upv,
                       input logic ld, input logic [3:0] lv);
    @(negedge clk);
    bus.enable     = en;
    bus.speed      = spd;
    bus.up         = upv;
    bus.load       = ld;
    bus.load_value = lv;
    model_edge(en, spd, upv, ld, lv);
    exp_q.push_back('{tick: tick_m, hex: hex_m});
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("chk  %s value=%0h", name, act);
    end
  endtask

  // Sample just after the next rising edge.
  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  // Monitor: the DUT presents a new output after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.tick, bus.hex_value} !== e) begin
          failures++;
          $display("FAIL sb t=%0t actual tick=%0b hex=%0h required tick=%0b hex=%0h",
                   $time, bus.tick, bus.hex_value, e.tick, e.hex);
        end else begin
          $display("txn  t=%0t tick=%0b hex=%0h", $time, bus.tick, bus.hex_value);
        end
      end
    end
  end

  initial begin
    logic       en, upv, ld;
    logic [1:0] spd;
    logic [3:0] lv;

    bus.enable     = 1'b0;
    bus.speed      = 2'b00;
    bus.up         = 1'b1;
    bus.load       = 1'b0;
    bus.load_value = 4'h0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_tick", {7'd0, bus.tick}, 8'h00);
    check("reset_hex", {4'd0, bus.hex_value}, 8'h00);
    @(posedge clk);
    #1 resetn = 1'b1;

    // Full rate, counting up through the F->0 wrap
    repeat (20) drive(1'b1, 2'b00, 1'b1, 1'b0, 4'h0);
    settle();
    check("full_rate_hex", {4'd0, bus.hex_value}, 8'h04);
    check("full_rate_tick", {7'd0, bus.tick}, 8'h01);

    // 1x rate from 0: ticks 4 edges apart after the reload edge
    drive(1'b1, 2'b01, 1'b1, 1'b1, 4'h0);
    repeat (11) drive(1'b1, 2'b01, 1'b1, 1'b0, 4'h0);
    settle();
    check("rate1_hex", {4'd0, bus.hex_value}, 8'h02);

    // 4x rate down from 0: F after 16 cycles, E after 32
    drive(1'b1, 2'b11, 1'b0, 1'b1, 4'h0);
    repeat (32) drive(1'b1, 2'b11, 1'b0, 1'b0, 4'h0);
    settle();
    check("rate4_down_hex", {4'd0, bus.hex_value}, 8'h0E);
    check("rate4_down_tick", {7'd0, bus.tick}, 8'h01);

    // Load mid-period at 1x rate, then one full period to B
    drive(1'b1, 2'b01, 1'b1, 1'b0, 4'h0);
    repeat (2) drive(1'b1, 2'b01, 1'b1, 1'b0, 4'h0);
    drive(1'b1, 2'b01, 1'b1, 1'b1, 4'hA);
    settle();
    check("load_hex", {4'd0, bus.hex_value}, 8'h0A);
    check("load_tick", {7'd0, bus.tick}, 8'h00);
    repeat (4) drive(1'b1, 2'b01, 1'b1, 1'b0, 4'h0);
    settle();
    check("after_load_hex", {4'd0, bus.hex_value}, 8'h0B);

    // Freeze mid-period at 2x rate; remaining period completes afterwards
    drive(1'b1, 2'b10, 1'b1, 1'b0, 4'h0);
    repeat (3)  drive(1'b1, 2'b10, 1'b1, 1'b0, 4'h0);
    repeat (10) drive(1'b0, 2'b10, 1'b1, 1'b0, 4'h0);
    settle();
    check("frozen_hex", {4'd0, bus.hex_value}, 8'h0B);
    repeat (5) drive(1'b1, 2'b10, 1'b1, 1'b0, 4'h0);
    settle();
    check("resume_tick", {7'd0, bus.tick}, 8'h01);
    check("resume_hex", {4'd0, bus.hex_value}, 8'h0C);

    // Asynchronous reset between edges while showing 7 at 4x rate
    drive(1'b1, 2'b11, 1'b1, 1'b1, 4'h7);
    repeat (5) drive(1'b1, 2'b11, 1'b1, 1'b0, 4'h0);
    @(posedge clk);
    #4 resetn = 1'b0;
    #1;
    check("async_rst_hex", {4'd0, bus.hex_value}, 8'h00);
    check("async_rst_tick", {7'd0, bus.tick}, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    drive(1'b1, 2'b00, 1'b1, 1'b0, 4'h0);
    settle();
    check("post_rst_tick", {7'd0, bus.tick}, 8'h01);
    check("post_rst_hex", {4'd0, bus.hex_value}, 8'h01);

    // Randomised traffic against the model
    en  = 1'b1;
    spd = 2'b01;
    upv = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) spd = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) upv = ~upv;
      en = ($urandom_range(0, 7) != 0);
      ld = ($urandom_range(0, 24) == 0);
      lv = 4'($urandom_range(0, 15));
      drive(en, spd, upv, ld, lv);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 8'(exp_q.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
